vector_sequencer: RTL and testbench

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

---
 rtl/vector_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_vector_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_sequencer.sv
// Steps through a small vector table in wrap, one-shot or ping-pong order,
// presenting one registered entry per cycle while in RUN.
module vector_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] vector,
  output logic             vector_valid,
  output logic [IDX_W-1:0] index,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pass_count,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_WRAP = 2'd0;
  localparam logic [1:0] M_ONE  = 2'd1;
  localparam logic [1:0] M_PP   = 2'd2;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [15:0]      pcnt_q, pcnt_d;

  logic [1:0]       eff_mode;
  logic [IDX_W-1:0] rd_idx;
  logic             load;
  logic             pass_inc;

  // Table has no reset; a same-cycle read of the written address sees old data.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_C)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    // Ping-pong with one or two entries is identical to wrap; reserved mode wraps.
    eff_mode = M_WRAP;
    if (mode == M_ONE) begin
      eff_mode = M_ONE;
    end else if (mode == M_PP && DEPTH > 2) begin
      eff_mode = M_PP;
    end

    state_d  = state_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    vec_d    = vec_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    pcnt_d   = pcnt_q;
    rd_idx   = idx_q;
    load     = 1'b0;
    pass_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          mode_d  = eff_mode;
          dir_d   = 1'b0;
          rd_idx  = '0;
          load    = 1'b1;
          pcnt_d  = (eff_mode == M_WRAP && DEPTH == 1) ? 16'd1 : 16'd0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else begin
          case (mode_q)
            M_ONE: begin
              if (idx_q == IDX_LAST) begin
                state_d  = S_DONE;
                valid_d  = 1'b0;
                done_d   = 1'b1;
                pass_inc = 1'b1;
              end else begin
                rd_idx = idx_q + IDX_ONE;
                load   = 1'b1;
              end
            end
            M_PP: begin
              if (!dir_q) begin
                if (idx_q == IDX_LAST) begin
                  rd_idx = idx_q - IDX_ONE;
                  dir_d  = 1'b1;
                end else begin
                  rd_idx = idx_q + IDX_ONE;
                end
              end else begin
                if (idx_q == '0) begin
                  rd_idx = IDX_ONE;
                  dir_d  = 1'b0;
                end else begin
                  rd_idx = idx_q - IDX_ONE;
                end
              end
              load     = 1'b1;
              pass_inc = (rd_idx == '0);
            end
            default: begin
              rd_idx   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
              load     = 1'b1;
              pass_inc = (rd_idx == IDX_LAST);
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      vec_d   = mem_q[rd_idx];
      idx_d   = rd_idx;
      valid_d = 1'b1;
    end
    if (pass_inc && pcnt_q != 16'hFFFF) begin
      pcnt_d = pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= M_WRAP;
      dir_q   <= 1'b0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign vector       = vec_q;
  assign vector_valid = valid_q;
  assign index        = idx_q;
  assign busy         = (state_q == S_RUN);
  assign done         = done_q;
  assign pass_count   = pcnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: stimulus pushes expected {index, vector}
// pairs; a negedge monitor pops and compares every valid entry.
module tb_vector_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
  localparam int EW    = IDX_W + WIDTH;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       mode;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] vector;
  logic             vector_valid;
  logic [IDX_W-1:0] index;
  logic             busy;
  logic             done;
  logic [15:0]      pass_count;
  logic [1:0]       state_dbg;

  logic [EW-1:0]    exp_q[$];
  logic [WIDTH-1:0] tbl [DEPTH];
  int               errors;
  int               checks;

  vector_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .mode         (mode),
    .start        (start),
    .stop         (stop),
    .vector       (vector),
    .vector_valid (vector_valid),
    .index        (index),
    .busy         (busy),
    .done         (done),
    .pass_count   (pass_count),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_exp(input int idx);
    exp_q.push_back({IDX_W'(idx), tbl[idx]});
  endtask

  task automatic write_entry(input int addr, input logic [WIDTH-1:0] data);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(addr);
    wr_data = data;
    tbl[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && vector_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream: unexpected entry idx=%0d vec=%0h", index, vector);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("stream", {22'd0, index, vector}, {22'd0, e});
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    mode = 2'd0; start = 1'b0; stop = 1'b0;
    #2;
    chk("rst_vector", vector, 0);
    chk("rst_valid", vector_valid, 0);
    chk("rst_index", index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass_count, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b1;

    write_entry(0, 8'h08);
    write_entry(1, 8'h55);
    write_entry(2, 8'h94);
    write_entry(3, 8'hDA);

    // wrap, then stop together with start at index 2
    mode = 2'd0; start = 1'b1;
    for (int i = 0; i < 11; i++) push_exp(i % DEPTH);
    @(negedge clk); start = 1'b0;
    chk("wrap_first_valid", vector_valid, 1);
    chk("wrap_first_idx", index, 0);
    chk("wrap_first_vec", vector, 8'h08);
    chk("wrap_busy", busy, 1);
    cycles(2);
    chk("wrap_pass0", pass_count, 0);
    cycles(1);
    chk("wrap_pass1", pass_count, 1);
    cycles(4);
    chk("wrap_pass2", pass_count, 2);
    cycles(3);
    chk("wrap_idx_at_stop", index, 2);
    start = 1'b1; stop = 1'b1;
    cycles(1); start = 1'b0; stop = 1'b0;
    chk("stop_valid", vector_valid, 0);
    chk("stop_index_hold", index, 2);
    chk("stop_vec_hold", vector, 8'h94);
    chk("stop_busy", busy, 0);
    chk("stop_pass_hold", pass_count, 2);
    cycles(2);
    chk("stop_no_restart", vector_valid, 0);
    chk("stop_state", state_dbg, 0);

    // one-shot; mode change mid-run must be ignored
    mode = 2'd1; start = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_exp(i);
    @(negedge clk); start = 1'b0; mode = 2'd0;
    chk("one_pass_clear", pass_count, 0);
    cycles(3);
    chk("one_last_idx", index, 3);
    chk("one_no_early_done", done, 0);
    cycles(1);
    chk("one_done", done, 1);
    chk("one_done_valid", vector_valid, 0);
    chk("one_done_busy", busy, 0);
    chk("one_pass", pass_count, 1);
    chk("one_state_done", state_dbg, 2);
    cycles(1);
    chk("one_done_pulse", done, 0);
    chk("one_state_idle", state_dbg, 0);

    // ping-pong
    mode = 2'd2; start = 1'b1;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3);
    push_exp(2); push_exp(1); push_exp(0); push_exp(1);
    @(negedge clk); start = 1'b0;
    chk("pp_pass_clear", pass_count, 0);
    cycles(5);
    chk("pp_pass_before", pass_count, 0);
    cycles(1);
    chk("pp_idx_return", index, 0);
    chk("pp_pass_after", pass_count, 1);
    cycles(1);
    stop = 1'b1;
    cycles(1); stop = 1'b0;
    chk("pp_stop_valid", vector_valid, 0);
    chk("pp_stop_pass", pass_count, 1);

    // write collides with read of address 1
    mode = 2'd0; start = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(i % DEPTH);
    tbl[1] = 8'hFF;
    push_exp(1);
    @(negedge clk); start = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hFF;
    cycles(1); wr_en = 1'b0;
    chk("coll_old_data", vector, 8'h55);
    cycles(4);
    chk("coll_new_data", vector, 8'hFF);
    stop = 1'b1;
    cycles(1); stop = 1'b0;

    // asynchronous reset mid-run, then immediate restart
    mode = 2'd0; start = 1'b1;
    push_exp(0); push_exp(1);
    @(negedge clk); start = 1'b0;
    cycles(1);
    #2 reset = 1'b0;
    #1;
    chk("arst_vector", vector, 0);
    chk("arst_valid", vector_valid, 0);
    chk("arst_index", index, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pass", pass_count, 0);
    chk("arst_state", state_dbg, 0);
    @(negedge clk);
    chk("arst_no_done", done, 0);
    reset = 1'b1; start = 1'b1;
    push_exp(0);
    @(negedge clk); start = 1'b0;
    chk("arst_restart_vec", vector, 8'h08);
    chk("arst_restart_valid", vector_valid, 1);
    stop = 1'b1;
    cycles(1); stop = 1'b0;
    cycles(1);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
